// File: rtl/pig_dice_roller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pig_dice_roller_if
//  Description : Controller <-> dice roller link. The controller owns the roll
//                request, seeding and statistics clear. The roller returns the
//                face, roll status and per-game statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pig_dice_roller_if;
  logic        en_roll;
  logic        seed_load;
  logic [15:0] seed;
  logic        clr_stats;
  logic [3:0]  dice;
  logic        rolling;
  logic        dice_valid;
  logic [15:0] roll_count;
  logic [15:0] ones_count;

  // Game controller side
  modport master (
    output en_roll, seed_load, seed, clr_stats,
    input  dice, rolling, dice_valid, roll_count, ones_count
  );

  // Dice roller side
  modport slave (
    input  en_roll, seed_load, seed, clr_stats,
    output dice, rolling, dice_valid, roll_count, ones_count
  );
endinterface
`default_nettype wire

// File: rtl/pig_dice_roller.sv
`default_nettype none
// ============================================================================
//  Module      : pig_dice_roller
//  Description : Pig dice source. Tumbles a 1..6 face every clock while
//                en_roll is high and freezes it when en_roll drops, so the
//                controller can use the face in its next state. Also keeps
//                saturating counts of completed rolls and of rolls ending on 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module pig_dice_roller #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter bit          RANDOM = 1'b1
) (
  input wire               clock,
  input wire               reset,
  pig_dice_roller_if.slave bus
);

  localparam logic [0:0]  c_IDLE    = 1'b0;
  localparam logic [0:0]  c_ROLLING = 1'b1;
  localparam logic [15:0] c_SAT     = 16'hFFFF;

  logic [15:0] r_lfsr;
  logic [3:0]  r_dice;
  logic [0:0]  r_state;
  logic        r_dice_valid;
  logic [15:0] r_roll_count;
  logic [15:0] r_ones_count;

  logic        w_lfsr_fb;
  logic [15:0] w_seed_val;
  logic [2:0]  w_step;
  logic [3:0]  w_sum;
  logic [3:0]  w_next_dice;
  logic [0:0]  w_next_state;
  logic        w_complete;

  // A zero load would lock the LFSR, so zero falls back to the reset seed.
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_seed_val = (bus.seed == 16'd0) ? SEED : bus.seed;

  // Step size: LFSR-driven 1..4 in normal operation, constant 1 for demos.
  generate
    if (RANDOM) begin : g_random_step
      assign w_step = 3'd1 + {1'b0, r_lfsr[1:0]};
    end else begin : g_fixed_step
      assign w_step = 3'd1;
    end
  endgenerate

  // Zero-based face plus step is at most 5 + 4 = 9, so one subtraction of 6
  // is enough to wrap it back into range before converting to 1-based.
  assign w_sum       = (r_dice - 4'd1) + {1'b0, w_step};
  assign w_next_dice = (w_sum >= 4'd6) ? (w_sum - 4'd5) : (w_sum + 4'd1);

  // The FSM follows en_roll directly; leaving ROLLING marks a finished roll.
  assign w_next_state = bus.en_roll ? c_ROLLING : c_IDLE;
  assign w_complete   = (r_state == c_ROLLING) && !bus.en_roll;

  // Free-running LFSR; a seed load replaces that cycle's shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (bus.seed_load) begin
      r_lfsr <= w_seed_val;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Tumble the face while rolling, hold it otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dice <= 4'd1;
    end else if (bus.en_roll) begin
      r_dice <= w_next_dice;
    end
  end

  // IDLE/ROLLING state register, exported as the rolling flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Face is valid from the completion edge until the next roll begins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dice_valid <= 1'b0;
    end else if (bus.en_roll) begin
      r_dice_valid <= 1'b0;
    end else if (w_complete) begin
      r_dice_valid <= 1'b1;
    end
  end

  // Saturating roll statistics; a clear wins over a same-cycle completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_roll_count <= 16'd0;
      r_ones_count <= 16'd0;
    end else if (bus.clr_stats) begin
      r_roll_count <= 16'd0;
      r_ones_count <= 16'd0;
    end else if (w_complete) begin
      if (r_roll_count != c_SAT) begin
        r_roll_count <= r_roll_count + 16'd1;
      end
      if ((r_dice == 4'd1) && (r_ones_count != c_SAT)) begin
        r_ones_count <= r_ones_count + 16'd1;
      end
    end
  end

  assign bus.dice       = r_dice;
  assign bus.rolling    = r_state[0];
  assign bus.dice_valid = r_dice_valid;
  assign bus.roll_count = r_roll_count;
  assign bus.ones_count = r_ones_count;

endmodule
`default_nettype wire

// File: tb/tb_pig_dice_roller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pig_dice_roller
//  Description : Bench for pig_dice_roller. Two instances (fixed step and
//                LFSR step) share one stimulus stream; a behavioural model of
//                each is stepped on every clock edge and compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pig_dice_roller;

  logic        clock = 1'b0;
  logic        reset;
  logic        en_roll;
  logic        seed_load;
  logic [15:0] seed;
  logic        clr_stats;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  pig_dice_roller_if bus0 ();
  pig_dice_roller_if bus1 ();

  assign bus0.en_roll   = en_roll;
  assign bus0.seed_load = seed_load;
  assign bus0.seed      = seed;
  assign bus0.clr_stats = clr_stats;
  assign bus1.en_roll   = en_roll;
  assign bus1.seed_load = seed_load;
  assign bus1.seed      = seed;
  assign bus1.clr_stats = clr_stats;

  pig_dice_roller #(.SEED(16'hACE1), .RANDOM(1'b0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  pig_dice_roller #(.SEED(16'hACE1), .RANDOM(1'b1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // ---------------- behavioural reference ----------------
  logic [15:0] m_lfsr  [2];
  int          m_dice  [2];
  bit          m_roll  [2];
  bit          m_valid [2];
  int          m_rc    [2];
  int          m_oc    [2];

  function automatic void model_reset(int k);
    m_lfsr[k]  = 16'hACE1;
    m_dice[k]  = 1;
    m_roll[k]  = 1'b0;
    m_valid[k] = 1'b0;
    m_rc[k]    = 0;
    m_oc[k]    = 0;
  endfunction

  function automatic void model_edge(int k, bit rnd);
    int   step;
    bit   done;
    logic fb;
    step = rnd ? 1 + (int'(m_lfsr[k]) % 4) : 1;
    done = m_roll[k] && !en_roll;
    fb   = m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10];
    if (seed_load) m_lfsr[k] = (seed == 16'd0) ? 16'hACE1 : seed;
    else           m_lfsr[k] = {m_lfsr[k][14:0], fb};
    if (en_roll) m_dice[k] = ((m_dice[k] - 1 + step) % 6) + 1;
    if (en_roll)   m_valid[k] = 1'b0;
    else if (done) m_valid[k] = 1'b1;
    if (clr_stats) begin
      m_rc[k] = 0;
      m_oc[k] = 0;
    end else if (done) begin
      if (m_rc[k] < 65535) m_rc[k]++;
      if (m_dice[k] == 1 && m_oc[k] < 65535) m_oc[k]++;
    end
    m_roll[k] = en_roll;
  endfunction

  // ---------------- checking ----------------
  task automatic check_value(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(int k, logic [3:0] d, logic r, logic v,
                           logic [15:0] rc, logic [15:0] oc, logic [15:0] lf);
    string p;
    p = (k == 0) ? "d0" : "d1";
    check_value({p, ".dice"},  {28'd0, d}, m_dice[k]);
    check_value({p, ".range"}, {31'd0, (d >= 4'd1 && d <= 4'd6)}, 32'd1);
    check_value({p, ".rolling"}, {31'd0, r}, {31'd0, m_roll[k]});
    check_value({p, ".valid"}, {31'd0, v}, {31'd0, m_valid[k]});
    check_value({p, ".rcount"}, {16'd0, rc}, m_rc[k]);
    check_value({p, ".ocount"}, {16'd0, oc}, m_oc[k]);
    check_value({p, ".lfsr"}, {16'd0, lf}, {16'd0, m_lfsr[k]});
  endtask

  task automatic check_both();
    check_dut(0, bus0.dice, bus0.rolling, bus0.dice_valid,
              bus0.roll_count, bus0.ones_count, dut0.r_lfsr);
    check_dut(1, bus1.dice, bus1.rolling, bus1.dice_valid,
              bus1.roll_count, bus1.ones_count, dut1.r_lfsr);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(0, 1'b0);
    model_edge(1, 1'b1);
    @(negedge clock);
    check_both();
  endtask

  task automatic apply_reset();
    @(negedge clock);
    en_roll   = 1'b0;
    seed_load = 1'b0;
    clr_stats = 1'b0;
    reset     = 1'b1;
    model_reset(0);
    model_reset(1);
    #1 check_both();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int exp_seq6 [6] = '{2, 3, 4, 5, 6, 1};
  int hist [16];

  initial begin
    reset     = 1'b1;
    en_roll   = 1'b0;
    seed_load = 1'b0;
    seed      = 16'd0;
    clr_stats = 1'b0;
    model_reset(0);
    model_reset(1);
    foreach (hist[i]) hist[i] = 0;

    // Reset values
    repeat (2) @(negedge clock);
    check_value("rst.dice",  {28'd0, bus0.dice}, 32'd1);
    check_value("rst.valid", {31'd0, bus0.dice_valid}, 32'd0);
    check_value("rst.roll",  {31'd0, bus1.rolling}, 32'd0);
    check_value("rst.rc",    {16'd0, bus1.roll_count}, 32'd0);
    check_value("rst.lfsr",  {16'd0, dut1.r_lfsr}, 32'hACE1);
    check_both();
    reset = 1'b0;

    // Roll on first edge after release, 3 edges long
    en_roll = 1'b1;
    tick();
    check_value("t1.e1.d0", {28'd0, bus0.dice}, 32'd2);
    check_value("t1.e1.d1", {28'd0, bus1.dice}, 32'd3);
    tick();
    check_value("t1.e2.d0", {28'd0, bus0.dice}, 32'd3);
    tick();
    check_value("t1.e3.d0", {28'd0, bus0.dice}, 32'd4);
    en_roll = 1'b0;
    #1 check_value("t1.valid_lo", {31'd0, bus0.dice_valid}, 32'd0);
    tick();
    check_value("t1.hold",   {28'd0, bus0.dice}, 32'd4);
    check_value("t1.valid",  {31'd0, bus0.dice_valid}, 32'd1);
    check_value("t1.rc",     {16'd0, bus0.roll_count}, 32'd1);
    check_value("t1.oc",     {16'd0, bus0.ones_count}, 32'd0);
    tick();
    check_value("t1.hold2",  {28'd0, bus0.dice}, 32'd4);

    // Six-edge roll wraps 6 -> 1, then an eight-edge roll ends on 3
    apply_reset();
    en_roll = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_value($sformatf("t2.seq%0d", i), {28'd0, bus0.dice}, exp_seq6[i]);
    end
    en_roll = 1'b0;
    tick();
    check_value("t2.oc", {16'd0, bus0.ones_count}, 32'd1);
    en_roll = 1'b1;
    repeat (8) tick();
    en_roll = 1'b0;
    tick();
    check_value("t2.final", {28'd0, bus0.dice}, 32'd3);
    check_value("t2.rc",    {16'd0, bus0.roll_count}, 32'd2);

    // Seed loads: zero falls back to ACE1, nonzero is taken as-is
    seed      = 16'd0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check_value("seed0.lfsr", {16'd0, dut1.r_lfsr}, 32'hACE1);
    seed      = 16'h1234;
    seed_load = 1'b1;
    en_roll   = 1'b1;
    tick();
    seed_load = 1'b0;
    check_value("seedN.lfsr", {16'd0, dut1.r_lfsr}, 32'h1234);
    en_roll = 1'b0;
    tick();

    // Reset in the middle of a roll
    apply_reset();
    en_roll = 1'b1;
    repeat (4) tick();
    check_value("mid.pre", {28'd0, bus0.dice}, 32'd5);
    reset = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    check_value("mid.dice",  {28'd0, bus0.dice}, 32'd1);
    check_value("mid.valid", {31'd0, bus0.dice_valid}, 32'd0);
    check_value("mid.roll",  {31'd0, bus0.rolling}, 32'd0);
    check_value("mid.rc",    {16'd0, bus0.roll_count}, 32'd0);
    check_both();
    en_roll = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Saturation of the roll counter, then clear on a completion edge
    force dut0.r_roll_count = 16'hFFFE;
    m_rc[0] = 16'hFFFE;
    tick();
    release dut0.r_roll_count;
    tick();
    for (int i = 0; i < 3; i++) begin
      en_roll = 1'b1;
      tick();
      en_roll = 1'b0;
      tick();
      check_value($sformatf("sat.rc%0d", i), {16'd0, bus0.roll_count}, 32'hFFFF);
    end
    en_roll = 1'b1;
    tick();
    en_roll   = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check_value("clr.rc", {16'd0, bus0.roll_count}, 32'd0);
    check_value("clr.oc", {16'd0, bus0.ones_count}, 32'd0);
    check_value("clr.valid", {31'd0, bus0.dice_valid}, 32'd1);

    // Randomized rolls against the model
    for (int r = 0; r < 10000; r++) begin
      int len;
      len     = $urandom_range(1, 5);
      en_roll = 1'b1;
      for (int i = 0; i < len; i++) begin
        seed_load = ($urandom_range(0, 199) == 0);
        seed      = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        clr_stats = ($urandom_range(0, 99) == 0);
        tick();
      end
      en_roll   = 1'b0;
      seed_load = 1'b0;
      clr_stats = ($urandom_range(0, 49) == 0);
      tick();
      hist[int'(bus1.dice)]++;
      clr_stats = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Final faces should be near-uniform: 10000/6 +/- 10%
    for (int f = 1; f <= 6; f++) begin
      check_value($sformatf("hist.face%0d(n=%0d)", f, hist[f]),
                  {31'd0, (hist[f] >= 1500 && hist[f] <= 1834)}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pig_dice_roller.md
Name: pig_dice_roller

Overview:
- Dice source for the Pig game controller; the responder side of the `en_roll`/`dice` interface.
- While the controller asserts `en_roll`, the block tumbles a 1..6 die value every clock.
- When `en_roll` drops, the value freezes, so the controller can sample `dice` combinationally in its next state.
- Also keeps per-game roll statistics for display and debug.

Parameters:
- `SEED`, 16'hACE1, LFSR reset value; also substitutes for an all-zero `seed` load.
- `RANDOM`, 1, 1 = LFSR-driven step of 1..4 per tumble; 0 = fixed step of 1 (bench/demo mode).

Ports:
- `clock`  input  1  system clock, rising edge
- `reset`  input  1  asynchronous, active-high
- `en_roll`  input  1  roll request from the game controller; level-sensitive
- `seed_load`  input  1  single-cycle pulse; loads `seed` into the LFSR
- `seed`  input  16  new LFSR state
- `clr_stats`  input  1  synchronous clear of the statistics counters
- `dice`  output  4  current die face, always in 1..6
- `rolling`  output  1  registered copy of `en_roll` (high while tumbling)
- `dice_valid`  output  1  final face of the last roll is stable
- `roll_count`  output  16  completed rolls since reset/clear, saturating
- `ones_count`  output  16  completed rolls that ended on 1, saturating

Behaviour:
- Reset is asynchronous, active-high, on `reset`; clock is `clock`. Reset values:
  - `lfsr` = SEED, `dice` = 4'd1, `rolling` = 0, `dice_valid` = 0.
  - `roll_count` = 0, `ones_count` = 0.
- LFSR:
  - 16-bit Fibonacci, free-running every cycle, independent of `en_roll`.
  - Next state = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - On `seed_load`, `lfsr` <= (`seed`==0 ? SEED : `seed`); the load replaces that cycle's shift.
  - Must never hold zero.
- Tumble (at each rising edge where `en_roll`==1):
  - step = RANDOM ? 1+lfsr[1:0] : 1.
  - `dice` <= ((dice-1+step) mod 6)+1.
  - The step uses the pre-edge `lfsr` value, including when `seed_load` is asserted in the same cycle.
- Hold: at edges with `en_roll`==0, `dice` is unchanged. The final face is the value registered at the last edge where `en_roll` was 1. No extra latency: the face is stable in the first cycle `en_roll` reads 0.
- `rolling` <= `en_roll` each edge. It is used for falling-edge detection (`rolling`==1 && `en_roll`==0).
- Two-state FSM, IDLE / ROLLING, mirrored by `rolling`:
  - IDLE -> ROLLING when `en_roll`=1.
  - ROLLING -> IDLE when `en_roll`=0; this edge is the completion edge.
- `dice_valid`:
  - Cleared to 0 at any edge where `en_roll`==1.
  - Set to 1 at the completion edge.
  - Otherwise holds.
  - Therefore high from one cycle after `en_roll` falls until the next roll starts.
- Statistics, updated at the completion edge:
  - `roll_count` += 1, saturating at 16'hFFFF.
  - `ones_count` += 1 if `dice`==1, saturating at 16'hFFFF.
  - `clr_stats` zeroes both counters and has priority over a same-cycle increment.
  - `clr_stats` does not touch `dice`, `lfsr` or `dice_valid`.
- Boundary cases:
  - A single-cycle `en_roll` produces exactly one tumble and one completion.
  - `en_roll` held across many cycles wraps 6->1 without ever producing 0 or 7.
  - Reset asserted mid-roll returns all state to reset values immediately. No completion is counted.
  - `en_roll` asserted on the first edge after reset release tumbles normally.
- `dice` upper bit is always 0. The widths of `dice` and the sum are sized for direct connection to the controller's 4-bit dice input.

Test Plan:
- RANDOM=0, `en_roll` high for exactly 3 edges after reset -> `dice` 2,3,4, holds 4; `dice_valid`=1 one cycle after `en_roll` falls; `roll_count`=1, `ones_count`=0.
- RANDOM=0, `en_roll` high 6 edges -> sequence 2..6,1, final 1; `ones_count`=1. Then 8 edges -> ends 3; `roll_count`=2.
- RANDOM=1, `en_roll` asserted at the first edge after reset release, 1 edge -> `lfsr`=ACE1 gives step 2, `dice`=3. `seed_load` with `seed`=0 -> `lfsr` reads ACE1 next cycle.
- RANDOM=1, 10,000 rolls of random length checked against a reference model -> `dice` always in 1..6, exact match every cycle, each face count within ±10% of 1/6.
- Reset asserted mid-roll (`en_roll` high, `dice`=5) -> `dice`=1, `dice_valid`=0, counters unchanged from 0, `rolling`=0 the same cycle.
- Force `roll_count` to FFFE, complete 3 rolls -> saturates at FFFF. `clr_stats` asserted on a completion edge -> both counters read 0.
